alu_cmd_feeder: RTL and testbench
=================================

# alu_cmd_feeder

Command buffer and issue stage placed directly upstream of `alu_top`. It accepts ALU commands (opcode and two operands) over a valid/ready handshake and stores them in a `DEPTH`-entry FIFO. It issues one command per cycle onto registered outputs that drive `alu_top`'s `i_sel_op`, `i_op_a` and `i_op_b`. A `LAT`-deep shift register follows each issued command and flags the cycle in which the matching ALU result appears on `o_res`.

## Interface
- `BITS`, 8, operand width; must equal the downstream `alu_top` `BITS`
- `DEPTH`, 4, FIFO entries; power of 2, ≥ 2
- `LAT`, 2, cycles from the issue edge to the cycle where `alu_top` `o_res` holds that command's result; ≥ 1
- `i_clk`  in  1  single clock, rising edge
- `i_rst`  in  1  reset, synchronous, active-high
- `i_valid`  in  1  upstream command valid
- `o_ready`  out  1  feeder can accept a command
- `i_sel_op`  in  5  command opcode
- `i_op_a`  in  BITS  command operand A
- `i_op_b`  in  BITS  command operand B
- `i_stall`  in  1  hold issue; no pop while high
- `o_sel_op`  out  5  issued opcode, registered
- `o_op_a`  out  BITS  issued operand A, registered
- `o_op_b`  out  BITS  issued operand B, registered
- `o_issue`  out  1  high for exactly the cycle in which a new command is first presented on `o_*`
- `o_res_valid`  out  1  the result for an issued command is on the ALU output this cycle
- `o_count`  out  $clog2(DEPTH+1)  FIFO occupancy
- `o_full`  out  1  `o_count == DEPTH`
- `o_empty`  out  1  `o_count == 0`

## Operation
- Push: the command is written at the FIFO write pointer on any edge where `i_valid && o_ready`. `o_ready = !o_full`, combinational from state only, with no dependence on `i_valid` or on a pop in the same cycle.
- Pop: occurs on any edge where `!o_empty && !i_stall`. The head entry is loaded into `o_sel_op`/`o_op_a`/`o_op_b`, and `o_issue` is set to 1 for the following cycle.
- No pop: `o_issue` is 0 next cycle. `o_sel_op`/`o_op_a`/`o_op_b` hold their last values and are not zeroed.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally from `DEPTH-1` to 0. `o_count` is a separate counter:
  - +1 on push only
  - −1 on pop only
  - unchanged on simultaneous push and pop
- Simultaneous push and pop:
  - Legal whenever not full.
  - When empty, no pop occurs: the entry written this edge is not visible to the pop logic until the next cycle. There is no write-through bypass.
- Result tracking: `LAT`-bit shift register. Bit 0 loads the pop condition on each edge; `o_res_valid` is the MSB. It shifts every cycle regardless of `i_stall`, because the ALU is free-running.
- Reset (`i_rst` high at an edge):
  - pointers, `o_count`, shift register → 0
  - `o_sel_op`, `o_op_a`, `o_op_b`, `o_issue` → 0
  - FIFO contents undefined and never observable
- Reset mid-operation discards all queued commands and in-flight `o_res_valid` flags.
- Reset values of the status outputs: `o_empty` = 1, `o_full` = 0, `o_ready` = 1, `o_res_valid` = 0.

## Timing
- Push-to-issue minimum latency is 1 cycle after the push edge. With a command pushed at edge k into an empty FIFO and no stall, it is popped at edge k+1, and `o_issue`=1 with the data on the outputs during cycle k+1…k+2.
- Issue-to-result: if the pop happens at edge p, `o_res_valid` = 1 during the cycle after edge p+LAT−1.
- Throughput is one command per cycle sustained when `i_valid`=1 and `i_stall`=0 continuously, with no bubbles after the first.
- `i_stall` is sampled at the edge. Stall high at edge p means no pop at p; stall low at p+1 means the pop happens at p+1.
- Full: `o_ready` is 0 in the cycle where `o_count == DEPTH`. A pop at that edge makes `o_ready` 1 the next cycle; accepting a push in the full cycle itself is not allowed.
- Only the combinational outputs `o_ready`, `o_full` and `o_empty` derive from registered state; all other outputs are registered.

## Test plan
- Reset check: assert `i_rst` 2 cycles → `o_empty`=1, `o_ready`=1, `o_count`=0, `o_issue`=0, `o_res_valid`=0, all `o_*` data = 0.
- Single command: push {op=3, a=0x12, b=0x34} at edge 0 → `o_issue`=1 after edge 1 with the same values, and `o_res_valid`=1 exactly `LAT` cycles after edge 1. Operands then hold at 0x12/0x34 with `o_issue`=0.
- Fill and overflow with `DEPTH`=4 and `i_stall`=1: push 5 commands on consecutive cycles → commands 1–4 accepted, `o_full`=1, `o_ready`=0, and the 5th is held off (its `i_valid` stays high). Release the stall → 4 consecutive issues in order, the 5th is accepted once `o_ready`=1, and the order is preserved across pointer wrap.
- Streaming: 16 back-to-back pushes with stall low → 16 consecutive `o_issue` pulses, `o_count` stays ≤ 1, and the `o_res_valid` pattern is 16 ones delayed by `LAT`.
- Mid-stream stall: stall for 3 cycles while 2 commands are queued → no `o_issue` during the stall and outputs frozen, while in-flight `o_res_valid` still asserts on schedule.
- Reset mid-operation: with 3 commands queued and 1 in flight, pulse `i_rst` → `o_count`=0, `o_res_valid` never asserts for the discarded command, and a fresh push issues normally.

Source files
------------

// File: rtl/alu_cmd_feeder.sv
`default_nettype none
// ============================================================================
// alu_cmd_feeder : command FIFO and issue stage feeding alu_top, with a
//                  result-valid tracker aligned to the ALU pipeline latency.
// Revision: 1.0
// ============================================================================
module alu_cmd_feeder #(
  parameter int BITS  = 8,
  parameter int DEPTH = 4,
  parameter int LAT   = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [4:0]                 i_sel_op,
  input  logic [BITS-1:0]            i_op_a,
  input  logic [BITS-1:0]            i_op_b,
  input  logic                       i_stall,
  output logic [4:0]                 o_sel_op,
  output logic [BITS-1:0]            o_op_a,
  output logic [BITS-1:0]            o_op_b,
  output logic                       o_issue,
  output logic                       o_res_valid,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [4:0]      mem_op_q [DEPTH];
  logic [BITS-1:0] mem_a_q  [DEPTH];
  logic [BITS-1:0] mem_b_q  [DEPTH];

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;
  logic [4:0]      sel_op_q, sel_op_d;
  logic [BITS-1:0] op_a_q,   op_a_d;
  logic [BITS-1:0] op_b_q,   op_b_d;
  logic            issue_q,  issue_d;
  logic [LAT-1:0]  res_sr_q, res_sr_d;

  logic w_full, w_empty, w_push, w_pop;

  assign w_full  = (count_q == CW'(DEPTH));
  assign w_empty = (count_q == '0);
  // Pop only sees entries committed on earlier edges, so a push into an
  // empty FIFO cannot be issued on the same edge.
  assign w_push  = i_valid && !w_full;
  assign w_pop   = !w_empty && !i_stall;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    sel_op_d = sel_op_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    issue_d  = 1'b0;
    if (w_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      sel_op_d = mem_op_q[rd_ptr_q];
      op_a_d   = mem_a_q[rd_ptr_q];
      op_b_d   = mem_b_q[rd_ptr_q];
      issue_d  = 1'b1;
    end
    if (w_push && !w_pop)      count_d = count_q + CW'(1);
    else if (!w_push && w_pop) count_d = count_q - CW'(1);
  end

  generate
    if (LAT == 1) begin : g_sr_single
      assign res_sr_d = w_pop;
    end else begin : g_sr_multi
      assign res_sr_d = {res_sr_q[LAT-2:0], w_pop};
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sel_op_q <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      issue_q  <= 1'b0;
      res_sr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sel_op_q <= sel_op_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      issue_q  <= issue_d;
      res_sr_q <= res_sr_d;
    end
  end

  // Storage needs no reset: nothing reads an entry before it is written.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_push) begin
      mem_op_q[wr_ptr_q] <= i_sel_op;
      mem_a_q[wr_ptr_q]  <= i_op_a;
      mem_b_q[wr_ptr_q]  <= i_op_b;
    end
  end

  assign o_ready     = !w_full;
  assign o_full      = w_full;
  assign o_empty     = w_empty;
  assign o_count     = count_q;
  assign o_sel_op    = sel_op_q;
  assign o_op_a      = op_a_q;
  assign o_op_b      = op_b_q;
  assign o_issue     = issue_q;
  assign o_res_valid = res_sr_q[LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_feeder.sv
`default_nettype none
// ============================================================================
// tb_alu_cmd_feeder : table vectors, directed corner sequences and random
//                     traffic checked against a queue-based reference model.
// Revision: 1.0
// ============================================================================
module tb_alu_cmd_feeder;

  localparam int BITS  = 8;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;
  localparam int CW    = $clog2(DEPTH+1);

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_valid = 1'b0;
  logic            o_ready;
  logic [4:0]      i_sel_op = '0;
  logic [BITS-1:0] i_op_a = '0;
  logic [BITS-1:0] i_op_b = '0;
  logic            i_stall = 1'b0;
  logic [4:0]      o_sel_op;
  logic [BITS-1:0] o_op_a;
  logic [BITS-1:0] o_op_b;
  logic            o_issue;
  logic            o_res_valid;
  logic [CW-1:0]   o_count;
  logic            o_full;
  logic            o_empty;

  alu_cmd_feeder #(.BITS(BITS), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_sel_op(i_sel_op), .i_op_a(i_op_a), .i_op_b(i_op_b), .i_stall(i_stall),
    .o_sel_op(o_sel_op), .o_op_a(o_op_a), .o_op_b(o_op_b), .o_issue(o_issue),
    .o_res_valid(o_res_valid), .o_count(o_count), .o_full(o_full),
    .o_empty(o_empty)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of pending commands, last issued command, and a
  // history of pop decisions (index 0 = most recent edge).
  logic [20:0] m_q[$];
  logic [20:0] m_out;
  logic        m_issue;
  bit          m_hist[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_rv();
    return (m_hist.size() >= LAT) ? m_hist[LAT-1] : 1'b0;
  endfunction

  // Advance model and DUT by one edge; sample outputs 1 time unit later.
  task automatic cyc();
    bit pop, push;
    if (i_rst) begin
      m_q.delete();
      m_hist.delete();
      m_out   = '0;
      m_issue = 1'b0;
    end else begin
      pop  = (m_q.size() > 0) && !i_stall;
      push = i_valid && (m_q.size() < DEPTH);
      m_issue = pop;
      if (pop) m_out = m_q.pop_front();
      if (push) m_q.push_back({i_sel_op, i_op_a, i_op_b});
      m_hist.push_front(pop);
      if (m_hist.size() > LAT) void'(m_hist.pop_back());
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_model();
    chk("count",     int'(o_count),     m_q.size());
    chk("empty",     int'(o_empty),     int'(m_q.size() == 0));
    chk("full",      int'(o_full),      int'(m_q.size() == DEPTH));
    chk("ready",     int'(o_ready),     int'(m_q.size() != DEPTH));
    chk("issue",     int'(o_issue),     int'(m_issue));
    chk("res_valid", int'(o_res_valid), int'(m_rv()));
    chk("sel_op",    int'(o_sel_op),    int'(m_out[20:16]));
    chk("op_a",      int'(o_op_a),      int'(m_out[15:8]));
    chk("op_b",      int'(o_op_b),      int'(m_out[7:0]));
  endtask

  task automatic drive(input bit rst, input bit v, input bit st, input logic [20:0] c);
    i_rst    = rst;
    i_valid  = v;
    i_stall  = st;
    i_sel_op = c[20:16];
    i_op_a   = c[15:8];
    i_op_b   = c[7:0];
  endtask

  function automatic logic [20:0] rnd_cmd();
    return {5'($urandom_range(0, 31)), 8'($urandom), 8'($urandom)};
  endfunction

  typedef struct {
    bit rst; bit valid; bit stall; logic [20:0] cmd;
    int e_count; bit e_empty; bit e_issue; bit e_rv; logic [20:0] e_out;
  } vec_t;

  vec_t vt[6];

  initial begin
    // Reset then a single command: push at edge 2, pop at edge 3,
    // res_valid after edge 3+LAT-1, operands then held.
    vt[0] = '{1'b1, 1'b0, 1'b0, 21'h0,      0, 1'b1, 1'b0, 1'b0, 21'h0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 21'h0,      0, 1'b1, 1'b0, 1'b0, 21'h0};
    vt[2] = '{1'b0, 1'b1, 1'b0, 21'h031234, 1, 1'b0, 1'b0, 1'b0, 21'h0};
    vt[3] = '{1'b0, 1'b0, 1'b0, 21'h0,      0, 1'b1, 1'b1, 1'b0, 21'h031234};
    vt[4] = '{1'b0, 1'b0, 1'b0, 21'h0,      0, 1'b1, 1'b0, 1'b1, 21'h031234};
    vt[5] = '{1'b0, 1'b0, 1'b0, 21'h0,      0, 1'b1, 1'b0, 1'b0, 21'h031234};
    for (int i = 0; i < 6; i++) begin
      drive(vt[i].rst, vt[i].valid, vt[i].stall, vt[i].cmd);
      cyc();
      chk("tbl_count", int'(o_count),     vt[i].e_count);
      chk("tbl_empty", int'(o_empty),     int'(vt[i].e_empty));
      chk("tbl_ready", int'(o_ready),     1);
      chk("tbl_issue", int'(o_issue),     int'(vt[i].e_issue));
      chk("tbl_rv",    int'(o_res_valid), int'(vt[i].e_rv));
      chk("tbl_data",  int'({o_sel_op, o_op_a, o_op_b}), int'(vt[i].e_out));
    end

    // Fill with stall high; fifth command held off while full.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1, {5'(i + 1), 8'(8'h10 + i), 8'(8'h20 + i)});
      cyc();
      check_model();
    end
    chk("fill_full", int'(o_full), 1);
    chk("fill_ready", int'(o_ready), 0);
    drive(0, 1, 1, {5'd5, 8'h15, 8'h25});
    cyc();
    check_model();
    chk("held_count", int'(o_count), DEPTH);
    begin
      bit acc = 0;
      for (int n = 0; n < 10 && !acc; n++) begin
        acc = (m_q.size() < DEPTH);
        drive(0, 1, 0, {5'd5, 8'h15, 8'h25});
        cyc();
        check_model();
      end
      if (!acc) begin
        errors++;
        $display("FAIL hold_accept: got 0 expected 1");
      end
    end
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, '0);
      cyc();
      check_model();
    end

    // Streaming: 16 back-to-back pushes, no stall.
    for (int i = 0; i < 16 + LAT + 2; i++) begin
      drive(0, i < 16, 0, rnd_cmd());
      cyc();
      check_model();
      chk("stream_cnt_le1", int'(o_count <= 1), 1);
    end

    // Mid-stream stall with an in-flight result.
    drive(0, 1, 0, rnd_cmd()); cyc(); check_model();
    drive(0, 1, 0, rnd_cmd()); cyc(); check_model();
    drive(0, 1, 1, rnd_cmd()); cyc(); check_model();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, '0); cyc(); check_model();
      chk("stall_no_issue", int'(o_issue), 0);
    end
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, '0); cyc(); check_model();
    end

    // Reset with 3 queued and 1 in flight.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1, rnd_cmd()); cyc(); check_model();
    end
    drive(0, 0, 0, '0); cyc(); check_model();
    drive(1, 0, 1, '0); cyc(); check_model();
    chk("rst_mid_count", int'(o_count), 0);
    for (int i = 0; i < LAT + 1; i++) begin
      drive(0, 0, 0, '0); cyc(); check_model();
      chk("rst_mid_no_rv", int'(o_res_valid), 0);
    end
    drive(0, 1, 0, {5'd7, 8'hAA, 8'h55}); cyc(); check_model();
    drive(0, 0, 0, '0); cyc(); check_model();
    chk("fresh_issue", int'(o_issue), 1);
    for (int i = 0; i < LAT + 1; i++) begin
      drive(0, 0, 0, '0); cyc(); check_model();
    end

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) == 0, rnd_cmd());
      cyc();
      check_model();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
